// File: rtl/alarm_if.sv
// ---------------------------------------------------------------------------
// alarm_if : button, time-base and display/buzzer bundle for alarm_controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alarm_if;
  logic       up_status;
  logic       down_status;
  logic       center_pulse;
  logic       sec_tick;
  logic [5:0] cur_sec;
  logic [5:0] cur_min;
  logic [4:0] cur_hour;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [1:0] edit_mode;
  logic       armed;
  logic       ringing;
  logic       buzzer;

  modport slave (
    input  up_status, down_status, center_pulse, sec_tick,
    input  cur_sec, cur_min, cur_hour,
    output alarm_hour, alarm_min, edit_mode, armed, ringing, buzzer
  );

  modport master (
    output up_status, down_status, center_pulse, sec_tick,
    output cur_sec, cur_min, cur_hour,
    input  alarm_hour, alarm_min, edit_mode, armed, ringing, buzzer
  );
endinterface

`default_nettype wire

// File: rtl/alarm_controller.sv
// ---------------------------------------------------------------------------
// alarm_controller : alarm time editing with auto-repeat, ring/snooze/dismiss
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alarm_controller #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned RING_SECONDS  = 60,
  parameter int unsigned SNOOZE_MIN    = 5
) (
  input  logic clk,
  input  logic reset,
  alarm_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] EDIT_HOUR = 3'd1;
  localparam logic [2:0] EDIT_MIN  = 3'd2;
  localparam logic [2:0] RING      = 3'd3;
  localparam logic [2:0] SNOOZE    = 3'd4;

  localparam logic [31:0] c_rep_delay  = 32'(REPEAT_DELAY);
  localparam logic [31:0] c_rep_reload = 32'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  localparam logic [11:0] c_ring_last  = 12'(RING_SECONDS - 1);
  localparam logic [11:0] c_snooze_last = 12'(SNOOZE_MIN * 60 - 1);

  logic [2:0]  state, state_nx;
  logic        up_q, down_q, match_q;
  logic [31:0] rep_cnt;
  logic [11:0] sec_cnt;
  logic [4:0]  alarm_hour;
  logic [5:0]  alarm_min;
  logic [1:0]  edit_mode;
  logic        armed, ringing, buzzer;

  logic up_edge, down_edge, any_edge, single, rep_hit, inc, dec;
  logic match, match_rise;

  assign up_edge   = bus.up_status & ~up_q;
  assign down_edge = bus.down_status & ~down_q;
  assign any_edge  = up_edge | down_edge;
  assign single    = bus.up_status ^ bus.down_status;
  // Repeat steps only come from an uninterrupted single-button hold.
  assign rep_hit   = single & ~any_edge & (rep_cnt == c_rep_delay);
  assign inc       = single & bus.up_status & (up_edge | rep_hit);
  assign dec       = single & bus.down_status & (down_edge | rep_hit);

  assign match = armed & (bus.cur_hour == alarm_hour) & (bus.cur_min == alarm_min)
               & (bus.cur_sec == 6'd0);
  assign match_rise = match & ~match_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (match_rise)            state_nx = RING;
        else if (bus.center_pulse) state_nx = EDIT_HOUR;
      end
      EDIT_HOUR: if (bus.center_pulse) state_nx = EDIT_MIN;
      EDIT_MIN:  if (bus.center_pulse) state_nx = IDLE;
      RING: begin
        if (bus.center_pulse)                              state_nx = IDLE;
        else if (any_edge)                                 state_nx = SNOOZE;
        else if (bus.sec_tick && (sec_cnt == c_ring_last)) state_nx = IDLE;
      end
      SNOOZE: begin
        if (bus.center_pulse)                                state_nx = IDLE;
        else if (bus.sec_tick && (sec_cnt == c_snooze_last)) state_nx = RING;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      match_q    <= 1'b0;
      rep_cnt    <= 32'd0;
      sec_cnt    <= 12'd0;
      alarm_hour <= 5'd0;
      alarm_min  <= 6'd0;
      edit_mode  <= 2'd0;
      armed      <= 1'b0;
      ringing    <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      state   <= state_nx;
      up_q    <= bus.up_status;
      down_q  <= bus.down_status;
      match_q <= match;

      if (!single)       rep_cnt <= 32'd0;
      else if (any_edge) rep_cnt <= 32'd1;
      else if (rep_hit)  rep_cnt <= c_rep_reload;
      else               rep_cnt <= rep_cnt + 32'd1;

      if (state_nx != state)
        sec_cnt <= 12'd0;
      else if (bus.sec_tick && (state == RING || state == SNOOZE))
        sec_cnt <= sec_cnt + 12'd1;

      if (state == EDIT_HOUR) begin
        if (inc)      alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
        else if (dec) alarm_hour <= (alarm_hour == 5'd0) ? 5'd23 : alarm_hour - 5'd1;
      end
      if (state == EDIT_MIN) begin
        if (inc)      alarm_min <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
        else if (dec) alarm_min <= (alarm_min == 6'd0) ? 6'd59 : alarm_min - 6'd1;
      end

      if (state == IDLE && state_nx == IDLE && any_edge)
        armed <= ~armed;
      else if (state == EDIT_MIN && bus.center_pulse)
        armed <= 1'b1;

      case (state_nx)
        EDIT_HOUR: edit_mode <= 2'd1;
        EDIT_MIN:  edit_mode <= 2'd2;
        default:   edit_mode <= 2'd0;
      endcase

      ringing <= (state_nx == RING);
      if (state_nx != RING)   buzzer <= 1'b0;
      else if (state != RING) buzzer <= 1'b1;
      else if (bus.sec_tick)  buzzer <= ~buzzer;
    end
  end

  assign bus.alarm_hour = alarm_hour;
  assign bus.alarm_min  = alarm_min;
  assign bus.edit_mode  = edit_mode;
  assign bus.armed      = armed;
  assign bus.ringing    = ringing;
  assign bus.buzzer     = buzzer;

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_controller : directed stimulus with a queued-expectation monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alarm_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  alarm_if bus ();

  alarm_controller #(
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4),
    .RING_SECONDS (3),
    .SNOOZE_MIN   (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic [1:0] mode;
    logic       armed;
    logic       ring;
    logic       buz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Monitor: one pending expectation is compared against the outputs mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.alarm_hour !== e.h || bus.alarm_min !== e.m || bus.edit_mode !== e.mode ||
          bus.armed !== e.armed || bus.ringing !== e.ring || bus.buzzer !== e.buz) begin
        errors++;
        $display("FAIL %s: got h=%0d m=%0d mode=%0d armed=%0b ringing=%0b buzzer=%0b, expected h=%0d m=%0d mode=%0d armed=%0b ringing=%0b buzzer=%0b",
                 e.name, bus.alarm_hour, bus.alarm_min, bus.edit_mode, bus.armed, bus.ringing,
                 bus.buzzer, e.h, e.m, e.mode, e.armed, e.ring, e.buz);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input string name, input int h, input int m, input int mode,
                          input bit a, input bit r, input bit b);
    exp_t e;
    e.name = name; e.h = 5'(h); e.m = 6'(m); e.mode = 2'(mode);
    e.armed = a; e.ring = r; e.buz = b;
    sb.push_back(e);
  endtask

  task automatic press_up();
    bus.up_status = 1'b1; cyc(1); bus.up_status = 1'b0; cyc(1);
  endtask

  task automatic press_down();
    bus.down_status = 1'b1; cyc(1); bus.down_status = 1'b0; cyc(1);
  endtask

  task automatic center();
    bus.center_pulse = 1'b1; cyc(1); bus.center_pulse = 1'b0;
  endtask

  task automatic tick();
    bus.sec_tick = 1'b1; cyc(1); bus.sec_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.up_status = 1'b0; bus.down_status = 1'b0; bus.center_pulse = 1'b0;
    bus.sec_tick = 1'b0;
    bus.cur_hour = 5'd12; bus.cur_min = 6'd0; bus.cur_sec = 6'd5;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    push_exp("reset", 0, 0, 0, 0, 0, 0);

    // Edit with wrap
    center();
    push_exp("enter_edit_hour", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 23; i++) press_up();
    push_exp("hour_23", 23, 0, 1, 0, 0, 0);
    press_up();
    push_exp("hour_wrap_up", 0, 0, 1, 0, 0, 0);
    center();
    press_down();
    push_exp("min_wrap_down", 0, 59, 2, 0, 0, 0);
    center();
    push_exp("edit_done", 0, 59, 0, 1, 0, 0);

    // Auto-repeat
    center();
    bus.up_status = 1'b1;
    cyc(8);
    push_exp("repeat_pre", 1, 59, 1, 1, 0, 0);
    cyc(1);
    push_exp("repeat_first", 2, 59, 1, 1, 0, 0);
    cyc(11);
    push_exp("repeat_hold", 4, 59, 1, 1, 0, 0);
    bus.up_status = 1'b0;
    cyc(10);
    push_exp("repeat_release", 4, 59, 1, 1, 0, 0);
    bus.up_status = 1'b1; bus.down_status = 1'b1;
    cyc(20);
    push_exp("both_held", 4, 59, 1, 1, 0, 0);
    bus.up_status = 1'b0; bus.down_status = 1'b0;
    cyc(2);

    // Program 07:30
    for (int i = 0; i < 3; i++) press_up();
    center();
    for (int i = 0; i < 29; i++) press_down();
    push_exp("set_0730", 7, 30, 2, 1, 0, 0);
    center();
    cyc(1);

    // Ring and timeout
    bus.cur_hour = 5'd7; bus.cur_min = 6'd30; bus.cur_sec = 6'd0;
    cyc(1);
    push_exp("ring_start", 7, 30, 0, 1, 1, 1);
    tick();
    push_exp("buzz_tick1", 7, 30, 0, 1, 1, 0);
    tick();
    push_exp("buzz_tick2", 7, 30, 0, 1, 1, 1);
    tick();
    push_exp("ring_timeout", 7, 30, 0, 1, 0, 0);
    cyc(5);
    push_exp("no_rering", 7, 30, 0, 1, 0, 0);

    // Snooze
    bus.cur_sec = 6'd1; cyc(1);
    bus.cur_sec = 6'd0; cyc(1);
    push_exp("ring_again", 7, 30, 0, 1, 1, 1);
    press_up();
    push_exp("snooze", 7, 30, 0, 1, 0, 0);
    for (int i = 0; i < 59; i++) tick();
    push_exp("snooze_wait", 7, 30, 0, 1, 0, 0);
    tick();
    push_exp("snooze_ring", 7, 30, 0, 1, 1, 1);
    center();
    push_exp("dismiss", 7, 30, 0, 1, 0, 0);

    // Disarm, then match must not ring
    bus.cur_sec = 6'd1; cyc(1);
    press_up();
    push_exp("disarm", 7, 30, 0, 0, 0, 0);
    bus.cur_sec = 6'd0; cyc(3);
    push_exp("disarmed_no_ring", 7, 30, 0, 0, 0, 0);
    bus.cur_sec = 6'd1; cyc(1);
    press_up();
    push_exp("rearm", 7, 30, 0, 1, 0, 0);

    // Match edge beats center_pulse
    bus.cur_sec = 6'd0; bus.center_pulse = 1'b1;
    cyc(1);
    bus.center_pulse = 1'b0;
    push_exp("match_over_center", 7, 30, 0, 1, 1, 1);
    cyc(1);

    // Asynchronous reset between clock edges
    #1;
    reset = 1'b1;
    #1;
    push_exp("async_reset", 0, 0, 0, 0, 0, 0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    push_exp("post_reset", 0, 0, 0, 0, 0, 0);

    cyc(3);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
